// File: rtl/timing_pkg.sv
// Shared types and constants for the timing-core memory loader.
package timing_pkg;
  localparam int DATA_W_DEF = 17;
  localparam int ADDR_W_DEF = 9;
  localparam int PPL_W      = 10;
  localparam int SEL_W      = 3;
  // word layout: active-pixel flag above a 16-bit timestamp
  localparam int ACTIVE_BIT = 16;
  localparam int TS_MSB     = 15;
  localparam int TS_LSB     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_PAD,
    ST_DONE
  } state_t;
endpackage

// File: rtl/timing_mem_loader_edge.sv
// Registered rising-edge detector for level request lines.
module edge_detector (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) d_q <= 1'b0;
    else         d_q <= d;

  assign rise = d & ~d_q;
endmodule

// File: rtl/timing_mem_loader.sv
// Refills one timing-core memory bank per update_mem request from a word stream.
// Optional watchdog on a stalled stream: define LOADER_TIMEOUT_EN.
module timing_mem_loader import timing_pkg::*; #(
  parameter int                NUM_BANKS   = 2,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PAD_WORD    = '0,
  parameter logic [15:0]       TIMEOUT_CYC = 16'hFFFF
)(
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              update_mem_i,
  input  logic [PPL_W-1:0]  points_per_line_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic [SEL_W-1:0]  memory_selector_o,
  output logic              mem_updated_o,
  output logic              busy_o,
  output logic              err_short_o,
`ifdef LOADER_TIMEOUT_EN
  output logic              err_timeout_o,
`endif
  output logic              err_long_o
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            state, nstate;
  logic [PPL_W-1:0]  n_q, idx;
  logic [SEL_W-1:0]  ptr;
  logic              pend, rise, hs, last_idx, take, n_zero, n_big, tmo;

  edge_detector u_req_edge (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .d      (update_mem_i),
    .rise   (rise)
  );

  assign s_ready_o     = (state == ST_LOAD) || (state == ST_DRAIN);
  assign mem_updated_o = (state == ST_DONE);
  assign busy_o        = (state != ST_IDLE);
  assign hs            = s_valid_i & s_ready_o;
  assign last_idx      = (idx == n_q - 1'b1);
  assign n_zero        = (points_per_line_i == '0);
  assign n_big         = 32'(points_per_line_i) > DEPTH;

`ifdef LOADER_TIMEOUT_EN
  logic [15:0] cnt;

  // tmo fires on the TIMEOUT_CYC-th consecutive cycle without a handshake
  assign tmo = s_ready_o && !hs && (cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      cnt           <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      if (!s_ready_o || hs) cnt <= '0;
      else                  cnt <= cnt + 16'd1;
      if (tmo) err_timeout_o <= 1'b1;
    end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) state <= ST_IDLE;
    else         state <= nstate;

  always_comb begin
    nstate = state;
    take   = 1'b0;
    case (state)
      ST_IDLE:
        if (pend) begin
          take   = 1'b1;
          nstate = (n_zero || n_big) ? ST_DONE : ST_LOAD;
        end
      ST_LOAD:
        if (hs) begin
          if (last_idx)      nstate = s_last_i ? ST_DONE : ST_DRAIN;
          else if (s_last_i) nstate = ST_PAD;
        end else if (tmo) begin
          nstate = ST_PAD;
        end
      ST_DRAIN:
        if ((hs && s_last_i) || tmo) nstate = ST_DONE;
      ST_PAD:
        if (last_idx) nstate = ST_DONE;
      ST_DONE:  nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      pend              <= 1'b0;
      n_q               <= '0;
      idx               <= '0;
      ptr               <= '0;
      we_o              <= 1'b0;
      waddr_o           <= '0;
      wdata_o           <= '0;
      memory_selector_o <= '0;
      err_short_o       <= 1'b0;
      err_long_o        <= 1'b0;
    end else begin
      we_o <= 1'b0;
      // a new edge in the same cycle a request is taken stays pending
      pend <= rise | (pend & ~take);
      case (state)
        ST_IDLE:
          if (take) begin
            n_q               <= points_per_line_i;
            idx               <= '0;
            memory_selector_o <= ptr;
            if (n_big) err_long_o <= 1'b1;
          end
        ST_LOAD:
          if (hs) begin
            we_o    <= 1'b1;
            waddr_o <= ADDR_W'(idx);
            wdata_o <= s_data_i;
            if (!last_idx) idx <= idx + 1'b1;
            if (last_idx && !s_last_i) err_long_o  <= 1'b1;
            if (!last_idx && s_last_i) err_short_o <= 1'b1;
          end
        ST_PAD: begin
          we_o    <= 1'b1;
          waddr_o <= ADDR_W'(idx);
          wdata_o <= PAD_WORD;
          if (!last_idx) idx <= idx + 1'b1;
        end
        ST_DONE:
          ptr <= (ptr == SEL_W'(NUM_BANKS - 1)) ? '0 : ptr + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: doc/timing_mem_loader.md
Name: timing_mem_loader

Overview:
- Sequences refills of the timing core's per-line timestamp/active-pixel memory banks from a valid/ready word stream.
- Answers the core's update_mem request, picks the target bank round-robin, writes one line of words, then pulses mem_updated.
- Sits between the host/DMA stream and the timing core memory write port (waddr/wdata/we/memory_selector).

Parameters:
NUM_BANKS, 2, number of memory banks cycled through (1..8)
ADDR_W, 9, memory address width
DATA_W, 17, word width: bit 16 = active pixel, bits 15:0 = timestamp
PAD_WORD, 17'h0, word written to unfilled addresses after a short line
TIMEOUT_CYC, 16'hFFFF, watchdog limit (only with LOADER_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
nrst_i  in  1  reset, asynchronous, active-low
update_mem_i  in  1  refill request from timing core (level; rising edge starts a request)
points_per_line_i  in  10  words per line; sampled at load start
s_valid_i  in  1  stream word valid
s_ready_o  out  1  stream ready
s_data_i  in  DATA_W  stream word
s_last_i  in  1  marks final word of a line
waddr_o  out  ADDR_W  memory write address
wdata_o  out  DATA_W  memory write data
we_o  out  1  memory write enable
memory_selector_o  out  3  target bank
mem_updated_o  out  1  one-cycle pulse: bank refilled
busy_o  out  1  load in progress
err_short_o  out  1  sticky: s_last_i before count reached
err_long_o  out  1  sticky: count reached without s_last_i

Behaviour:
- Reset: all outputs 0, bank pointer 0, FSM IDLE, request-pending flag 0.
- Request: rising edge of update_mem_i (registered edge detect) sets pending flag; edge during a load is held and served after DONE; further edges while pending are merged.
- FSM: IDLE -> LOAD when pending (clears pending, latches N = points_per_line_i, index = 0, memory_selector_o = bank pointer). N == 0 or N > 2^ADDR_W: IDLE -> DONE, no writes, err_long_o set for N > 2^ADDR_W.
- LOAD: s_ready_o = 1. Handshake (valid & ready) at cycle t -> we_o = 1 at t+1 with waddr_o = index, wdata_o = s_data_i; index += 1.
  - Handshake with index == N-1 and s_last_i -> DONE.
  - Handshake with index == N-1 and no s_last_i -> err_long_o, go to DRAIN.
  - Handshake with s_last_i and index < N-1 -> err_short_o, go to PAD.
- DRAIN: s_ready_o = 1, words accepted and discarded (we_o = 0) until a handshake with s_last_i -> DONE.
- PAD: s_ready_o = 0; writes PAD_WORD at index..N-1, one per cycle, then DONE.
- DONE: mem_updated_o = 1 for exactly one cycle; bank pointer = (ptr + 1) mod NUM_BANKS; -> IDLE.
- busy_o = 1 in LOAD, DRAIN, PAD, DONE.
- memory_selector_o holds its value outside a load.
- Error flags clear only on reset.
- Address wrap: index never exceeds N-1; no wraparound writes.

Optional Feature:
- LOADER_TIMEOUT_EN defined: a cycle counter in LOAD/DRAIN resets on each handshake. Reaching TIMEOUT_CYC goes to PAD (LOAD) or DONE (DRAIN) and sets sticky err_timeout_o (extra output port).
- Undefined: no counter, no port; the loader waits indefinitely.

Decomposition:
- Package timing_pkg: FSM state encoding (IDLE, LOAD, DRAIN, PAD, DONE), DATA_W/ADDR_W constants, word field bit positions.
- One sub-module is natural: reuse edgeDetector for update_mem_i.

Test Plan:
- N=4, NUM_BANKS=2, request, stream 4 words with last on 4th -> we_o at addrs 0..3 with matching data, selector 0, one mem_updated pulse; second request uses selector 1, third uses selector 0.
- N=4, last on 2nd word -> addrs 0,1 from stream, addrs 2,3 = PAD_WORD, err_short_o=1, s_ready_o=0 during pad, mem_updated pulse.
- N=3, 5 words with last on 5th -> only addrs 0..2 written, err_long_o=1, words 4 and 5 accepted, mem_updated after 5th.
- update_mem_i rises mid-load -> current load completes, then a second load starts immediately after the DONE pulse on the next bank.
- s_valid_i toggling every other cycle, N=8 -> exactly 8 writes, each one cycle after its handshake, no gaps or duplicates.
- nrst_i asserted mid-LOAD -> all outputs 0 and bank pointer 0 immediately; a fresh request after release writes bank 0 from addr 0.
